// File: rtl/aes_pkg.sv
// Shared AES-128 key-expansion definitions: controller states, sizes and
// 128-bit key word helpers.
package aes_pkg;

    localparam int unsigned NUM_ROUNDS = 10;
    localparam int unsigned KEY_W      = 128;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned ROUND_W    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EMIT,
        ST_G_REQ,
        ST_G_WAIT,
        ST_FIN
    } ks_state_t;

    // w0 occupies the most significant word of the key.
    typedef struct packed {
        logic [WORD_W-1:0] w0;
        logic [WORD_W-1:0] w1;
        logic [WORD_W-1:0] w2;
        logic [WORD_W-1:0] w3;
    } key_words_t;

    function automatic logic [WORD_W-1:0] key_word(input logic [KEY_W-1:0] key,
                                                   input logic [1:0]       idx);
        key_words_t kw;
        kw = key_words_t'(key);
        case (idx)
            2'd0:    return kw.w0;
            2'd1:    return kw.w1;
            2'd2:    return kw.w2;
            default: return kw.w3;
        endcase
    endfunction

    // XOR chain producing the next round key from G's output t.
    function automatic logic [KEY_W-1:0] next_round_key(input logic [KEY_W-1:0]  key,
                                                        input logic [WORD_W-1:0] t);
        key_words_t nk;
        nk.w0 = key_word(key, 2'd0) ^ t;
        nk.w1 = key_word(key, 2'd1) ^ nk.w0;
        nk.w2 = key_word(key, 2'd2) ^ nk.w1;
        nk.w3 = key_word(key, 2'd3) ^ nk.w2;
        return KEY_W'(nk);
    endfunction

endpackage

// File: rtl/key_schedule.sv
// AES-128 key-expansion controller: emits round keys 0..10 over valid/ready,
// using an external G word-transform stage between rounds.
module key_schedule
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [KEY_W-1:0]   key_in,
    output logic [KEY_W-1:0]   round_key,
    output logic [ROUND_W-1:0] key_round,
    output logic               key_valid,
    input  logic               key_ready,
    output logic               busy,
    output logic               done,
    output logic               g_enable,
    output logic [WORD_W-1:0]  g_word,
    output logic [ROUND_W-1:0] g_round,
    input  logic [WORD_W-1:0]  g_result,
    input  logic               g_done
);

    ks_state_t         state;
    ks_state_t         state_nxt;
    logic              load_key;
    logic              load_next;
    logic [KEY_W-1:0]  next_key_c;

    assign next_key_c = next_round_key(round_key, g_result);

    // State register; status outputs are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            g_enable  <= 1'b0;
        end else begin
            state     <= state_nxt;
            key_valid <= (state_nxt == ST_EMIT);
            busy      <= (state_nxt != ST_IDLE);
            done      <= (state_nxt == ST_FIN);
            g_enable  <= (state_nxt == ST_G_REQ);
        end
    end

    // Next-state and key-register load decode.
    always_comb begin
        state_nxt = state;
        load_key  = 1'b0;
        load_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_EMIT;
                    load_key  = 1'b1;
                end
            end
            ST_EMIT: begin
                if (key_ready) begin
                    if (key_round == ROUND_W'(NUM_ROUNDS)) begin
                        state_nxt = ST_FIN;
                    end else begin
                        state_nxt = ST_G_REQ;
                    end
                end
            end
            ST_G_REQ: begin
                state_nxt = ST_G_WAIT;
            end
            ST_G_WAIT: begin
                if (g_done) begin
                    state_nxt = ST_EMIT;
                    load_next = 1'b1;
                end
            end
            ST_FIN: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Key/round registers; G request operands track the held key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round_key <= '0;
            key_round <= '0;
            g_word    <= '0;
            g_round   <= ROUND_W'(1);
        end else if (load_key) begin
            round_key <= key_in;
            key_round <= '0;
            g_word    <= key_word(key_in, 2'd3);
            g_round   <= ROUND_W'(1);
        end else if (load_next) begin
            round_key <= next_key_c;
            key_round <= key_round + ROUND_W'(1);
            g_word    <= key_word(next_key_c, 2'd3);
            g_round   <= key_round + ROUND_W'(2);
        end
    end

endmodule
